// File: rtl/memory_stage_if.sv
// ---------------------------------------------------------------------------
// memory_stage_if
// Bundle of the signals between the M stage, the memory stage and the
// WB stage of the pipeline.
//
// Signalling: there is no valid/ready handshake on this bus. Every signal is
// sampled on every rising clock edge. The M-side inputs are presented by the
// upstream stage. The W-side outputs are a registered copy of them. A bubble
// is encoded as RFWEW=0. StallW/FlushW are level controls that the hazard
// unit owns.
//
// Signals (direction as seen from the memory stage, i.e. the slave modport):
//   RFWEM      in   register-file write enable of the instruction in M
//   MtoRFSelM  in   result source select (1 = memory data, 0 = ALU result)
//   DMWEM      in   data-memory write enable (store)
//   ALUOutM    in   ALU result; the low AWL bits form the word address
//   DMinM      in   store data
//   RFAM       in   destination register address
//   StallW     in   hold MEM/WB
//   FlushW     in   clear MEM/WB (wins over StallW)
//   DMOutM     out  combinational read data, used for forwarding
//   RFWEW, MtoRFSelW, DMOutW, ALUOutW, RFAW  out  MEM/WB register outputs
// ---------------------------------------------------------------------------
interface memory_stage_if #(
    parameter int AWL = 6,
    parameter int DWL = 32
);
    logic           RFWEM;
    logic           MtoRFSelM;
    logic           DMWEM;
    logic [DWL-1:0] ALUOutM;
    logic [DWL-1:0] DMinM;
    logic [AWL-2:0] RFAM;
    logic           StallW;
    logic           FlushW;

    logic [DWL-1:0] DMOutM;

    logic           RFWEW;
    logic           MtoRFSelW;
    logic [DWL-1:0] DMOutW;
    logic [DWL-1:0] ALUOutW;
    logic [AWL-2:0] RFAW;

    // Upstream / bench side: drives the M-stage signals and observes results.
    modport master (
        output RFWEM, MtoRFSelM, DMWEM, ALUOutM, DMinM, RFAM, StallW, FlushW,
        input  DMOutM, RFWEW, MtoRFSelW, DMOutW, ALUOutW, RFAW
    );

    // Memory stage side.
    modport slave (
        input  RFWEM, MtoRFSelM, DMWEM, ALUOutM, DMinM, RFAM, StallW, FlushW,
        output DMOutM, RFWEW, MtoRFSelW, DMOutW, ALUOutW, RFAW
    );
endinterface

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
// Memory (M) stage of a five-stage pipeline: a DEPTH x DWL data memory with
// asynchronous read and synchronous write, followed by the MEM/WB pipeline
// register.
//
// Ports:
//   CLK   single clock, all state updates on its rising edge
//   RST   synchronous active-high reset (clears MEM/WB, blocks the store of
//         that cycle, never clears the memory contents)
//   bus   memory_stage_if.slave; see the interface file for the signal list
//
// Behaviour summary:
//   - Word address is ALUOutM[AWL-1:0]; higher ALUOutM bits are ignored, so
//     addresses alias modulo 2**AWL.
//   - DMOutM is the current memory contents at that address. A store in the
//     same cycle is visible only from the next cycle (read-before-write).
//   - StallW/FlushW affect the pipeline register only; stores are gated
//     solely by DMWEM and RST.
//   - MEM/WB priority: RST, then FlushW, then StallW, else capture.
// ---------------------------------------------------------------------------
module memory_stage #(
    parameter int AWL   = 6,
    parameter int DWL   = 32,
    parameter int DEPTH = 2 ** AWL
) (
    input  logic           CLK,
    input  logic           RST,
    memory_stage_if.slave  bus
);

    // -----------------------------------------------------------------------
    // Data memory
    // -----------------------------------------------------------------------
    logic [DWL-1:0] mem [DEPTH];
    logic [AWL-1:0] addr;

    // Only the low AWL bits select a word; the rest of the ALU result is
    // deliberately ignored.
    assign addr = bus.ALUOutM[AWL-1:0];

    // Asynchronous read. Because the write below is non-blocking, a store to
    // the same address in this cycle is not visible here until after the
    // edge, which gives the required read-before-write behaviour.
    assign bus.DMOutM = mem[addr];

    // Synchronous write. No reset of the array: reset only suppresses the
    // store issued in the reset cycle. StallW/FlushW are intentionally not
    // part of this condition.
    always_ff @(posedge CLK) begin
        if (!RST && bus.DMWEM) begin
            mem[addr] <= bus.DMinM;
        end
    end

    // -----------------------------------------------------------------------
    // MEM/WB pipeline register
    // -----------------------------------------------------------------------
    logic           rfwe_q;
    logic           mtorf_q;
    logic [DWL-1:0] dmout_q;
    logic [DWL-1:0] aluout_q;
    logic [AWL-2:0] rfa_q;

    always_ff @(posedge CLK) begin
        if (RST || bus.FlushW) begin
            // Reset and flush both produce an all-zero bubble; reset takes
            // precedence simply by being in the same branch ahead of stall.
            rfwe_q   <= 1'b0;
            mtorf_q  <= 1'b0;
            dmout_q  <= '0;
            aluout_q <= '0;
            rfa_q    <= '0;
        end else if (!bus.StallW) begin
            rfwe_q   <= bus.RFWEM;
            mtorf_q  <= bus.MtoRFSelM;
            dmout_q  <= bus.DMOutM;
            aluout_q <= bus.ALUOutM;
            rfa_q    <= bus.RFAM;
        end
        // StallW=1 with no flush/reset: every field holds.
    end

    assign bus.RFWEW     = rfwe_q;
    assign bus.MtoRFSelW = mtorf_q;
    assign bus.DMOutW    = dmout_q;
    assign bus.ALUOutW   = aluout_q;
    assign bus.RFAW      = rfa_q;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
// Self-checking bench for memory_stage. A reference model (a plain array for
// the data memory and a record of expected MEM/WB outputs) is advanced from
// the architectural rules once per cycle. Directed scenarios come first,
// followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_memory_stage;

    localparam int AWL   = 6;
    localparam int DWL   = 32;
    localparam int DEPTH = 2 ** AWL;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    memory_stage_if #(.AWL(AWL), .DWL(DWL)) bus ();

    memory_stage #(.AWL(AWL), .DWL(DWL), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    logic [DWL-1:0] m_mem [DEPTH];
    logic           e_rfwe;
    logic           e_mtorf;
    logic [DWL-1:0] e_dmo;
    logic [DWL-1:0] e_alu;
    logic [AWL-2:0] e_rfa;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DWL-1:0] obs,
                         input logic [DWL-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock cycle: drive M inputs, check the combinational read, apply
    // the edge to the model, then check all MEM/WB outputs.
    task automatic cycle(input logic rst, input logic rfwe, input logic mtorf,
                         input logic dmwe, input logic [DWL-1:0] alu,
                         input logic [DWL-1:0] din, input logic [AWL-2:0] rfa,
                         input logic stall, input logic flush);
        int a;
        logic [DWL-1:0] rd;
        RST           = rst;
        bus.RFWEM     = rfwe;
        bus.MtoRFSelM = mtorf;
        bus.DMWEM     = dmwe;
        bus.ALUOutM   = alu;
        bus.DMinM     = din;
        bus.RFAM      = rfa;
        bus.StallW    = stall;
        bus.FlushW    = flush;
        #2;
        a  = int'(alu % DEPTH);
        rd = m_mem[a];
        check("dmoutm", bus.DMOutM, rd);

        // Architectural next state.
        if (rst || flush) begin
            e_rfwe = 0; e_mtorf = 0; e_dmo = 0; e_alu = 0; e_rfa = 0;
        end else if (!stall) begin
            e_rfwe = rfwe; e_mtorf = mtorf; e_dmo = rd; e_alu = alu; e_rfa = rfa;
        end
        if (!rst && dmwe) m_mem[a] = din;

        @(posedge CLK);
        #1;
        check("rfwew",     {31'd0, bus.RFWEW},      {31'd0, e_rfwe});
        check("mtorfselw", {31'd0, bus.MtoRFSelW},  {31'd0, e_mtorf});
        check("dmoutw",    bus.DMOutW,              e_dmo);
        check("aluoutw",   bus.ALUOutW,             e_alu);
        check("rfaw",      {27'd0, bus.RFAW},       {27'd0, e_rfa});
    endtask

    // Shorthand for plain store / load cycles with no stall or flush.
    task automatic store(input logic [DWL-1:0] alu, input logic [DWL-1:0] din);
        cycle(0, 0, 0, 1, alu, din, 5'd0, 0, 0);
    endtask

    initial begin
        logic [DWL-1:0] rnd_alu;
        RST = 1; bus.RFWEM = 0; bus.MtoRFSelM = 0; bus.DMWEM = 0;
        bus.ALUOutM = 0; bus.DMinM = 0; bus.RFAM = 0; bus.StallW = 0;
        bus.FlushW = 0;
        @(posedge CLK);
        #1;
        // Reset state of MEM/WB.
        check("rst_rfwew",  {31'd0, bus.RFWEW}, 32'd0);
        check("rst_aluoutw", bus.ALUOutW, 32'd0);
        check("rst_dmoutw",  bus.DMOutW,  32'd0);
        check("rst_rfaw",   {27'd0, bus.RFAW}, 32'd0);
        e_rfwe = 0; e_mtorf = 0; e_dmo = 0; e_alu = 0; e_rfa = 0;

        // Fill the memory with known data; FlushW keeps MEM/WB at zero
        // while the (still unknown) old contents would otherwise be captured.
        for (int i = 0; i < DEPTH; i++) begin
            RST = 0; bus.StallW = 0; bus.FlushW = 1; bus.DMWEM = 1;
            bus.ALUOutM = i; bus.DMinM = $urandom;
            m_mem[i] = bus.DMinM;
            @(posedge CLK);
            #1;
        end

        // Store then load, with forwarding read and one-cycle latency.
        store(32'h14, 32'hDEADBEEF);
        cycle(0, 1, 1, 0, 32'h14, 32'h0, 5'd5, 0, 0);
        check("st_ld_dmoutw", bus.DMOutW, 32'hDEADBEEF);
        check("st_ld_rfaw",   {27'd0, bus.RFAW}, 32'd5);

        // Same-cycle read and write: old value now, new value next cycle.
        store(32'd3, 32'h11);
        cycle(0, 0, 0, 1, 32'd3, 32'h22, 5'd0, 0, 0);
        check("rdw_new_value", bus.DMOutM, 32'h22);

        // Address aliasing: 0x47 maps onto word 7.
        store(32'h47, 32'hA5A5A5A5);
        cycle(0, 1, 1, 0, 32'h07, 32'h0, 5'd1, 0, 0);
        check("alias_dmoutw", bus.DMOutW, 32'hA5A5A5A5);

        // Stall for three cycles with changing inputs, then flush during stall.
        cycle(0, 1, 0, 0, 32'h1234, 32'h0, 5'd9, 0, 0);
        for (int i = 0; i < 3; i++)
            cycle(0, i[0], 1, 0, $urandom, $urandom, 5'(i + 2), 1, 0);
        check("stall_aluoutw", bus.ALUOutW, 32'h1234);
        cycle(0, 1, 1, 0, 32'h55, 32'h0, 5'd3, 1, 1);
        check("flush_aluoutw", bus.ALUOutW, 32'd0);

        // Reset during a stall with a store pending: store blocked, MEM/WB
        // cleared, then capture resumes on the next edge.
        store(32'd2, 32'h0BADF00D);
        cycle(0, 1, 0, 0, 32'hABCD, 32'h0, 5'd4, 0, 0);
        cycle(0, 0, 0, 0, 32'h1, 32'h0, 5'd0, 1, 0);
        cycle(1, 1, 1, 1, 32'd9, 32'h55, 5'd7, 1, 0);
        check("rst_stall_aluoutw", bus.ALUOutW, 32'd0);
        cycle(0, 1, 1, 0, 32'd9, 32'h0, 5'd6, 0, 0);
        check("rst_mem9_kept", bus.DMOutW, m_mem[9]);
        cycle(0, 1, 1, 0, 32'd2, 32'h0, 5'd6, 0, 0);
        check("mem2_after_rst", bus.DMOutW, 32'h0BADF00D);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rnd_alu = $urandom;
            if ($urandom_range(0, 1) == 1) rnd_alu = rnd_alu & 32'h0000_000F;
            cycle($urandom_range(0, 29) == 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) == 0, rnd_alu, $urandom,
                  5'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
